// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports with write-first
// bypass, hardwired $zero, and a post-reset clear sequencer in place of a per-entry reset.
module register_file #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 5,
  parameter int unsigned REGISTER_COUNT = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     register_read_enable_a,
  input  logic [ADDRESS_WIDTH-1:0] register_read_address_a,
  output logic [DATA_WIDTH-1:0]    register_read_data_a,
  input  logic                     register_read_enable_b,
  input  logic [ADDRESS_WIDTH-1:0] register_read_address_b,
  output logic [DATA_WIDTH-1:0]    register_read_data_b,
  input  logic                     register_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] register_write_address,
  input  logic [DATA_WIDTH-1:0]    register_write_data,
  input  logic [ADDRESS_WIDTH-1:0] debug_address,
  output logic [DATA_WIDTH-1:0]    debug_data,
  output logic                     ready,
  output logic                     write_dropped
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_INDEX = ADDRESS_WIDTH'(REGISTER_COUNT - 1);
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_INDEX = ADDRESS_WIDTH'(1);

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] clear_index_q;
  logic                     ready_q;
  logic                     write_dropped_q;
  logic [DATA_WIDTH-1:0]    regs_q [REGISTER_COUNT];

  logic write_request;
  logic write_commit;
  logic bypass_ok;

  // Writes to $zero are not requests at all, so they never set the drop flag.
  assign write_request = register_write_enable && (register_write_address != '0);
  assign write_commit  = write_request && !reset && (state_q == READY);
  assign bypass_ok     = register_write_enable && (state_q == READY);

  // Control FSM: clear sequencer walks entries 1..REGISTER_COUNT-1, then holds READY.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= CLEAR;
      clear_index_q   <= FIRST_INDEX;
      ready_q         <= 1'b0;
      write_dropped_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      clear_index_q <= clear_index_q + FIRST_INDEX;
      if (write_request) begin
        write_dropped_q <= 1'b1;
      end
      if (clear_index_q == LAST_INDEX) begin
        state_q <= READY;
        ready_q <= 1'b1;
      end
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clock) begin
    if (!reset && (state_q == CLEAR)) begin
      regs_q[clear_index_q] <= '0;
    end else if (write_commit) begin
      regs_q[register_write_address] <= register_write_data;
    end
  end

  always_comb begin
    register_read_data_a = '0;
    if (!reset && ready_q && register_read_enable_a && (register_read_address_a != '0)) begin
      if (bypass_ok && (register_write_address == register_read_address_a)) begin
        register_read_data_a = register_write_data;
      end else begin
        register_read_data_a = regs_q[register_read_address_a];
      end
    end
  end

  always_comb begin
    register_read_data_b = '0;
    if (!reset && ready_q && register_read_enable_b && (register_read_address_b != '0)) begin
      if (bypass_ok && (register_write_address == register_read_address_b)) begin
        register_read_data_b = register_write_data;
      end else begin
        register_read_data_b = regs_q[register_read_address_b];
      end
    end
  end

  // Debug view shows committed contents only.
  always_comb begin
    debug_data = '0;
    if (ready_q && (debug_address != '0)) begin
      debug_data = regs_q[debug_address];
    end
  end

  assign ready         = ready_q;
  assign write_dropped = write_dropped_q;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, clear/reset sequences and
// randomized traffic checked against a behavioural register model.
module tb_register_file;

  logic        clock;
  logic        reset;
  logic        register_read_enable_a;
  logic [4:0]  register_read_address_a;
  logic [31:0] register_read_data_a;
  logic        register_read_enable_b;
  logic [4:0]  register_read_address_b;
  logic [31:0] register_read_data_b;
  logic        register_write_enable;
  logic [4:0]  register_write_address;
  logic [31:0] register_write_data;
  logic [4:0]  debug_address;
  logic [31:0] debug_data;
  logic        ready;
  logic        write_dropped;

  register_file #(
    .DATA_WIDTH(32),
    .ADDRESS_WIDTH(5),
    .REGISTER_COUNT(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .register_read_enable_a(register_read_enable_a),
    .register_read_address_a(register_read_address_a),
    .register_read_data_a(register_read_data_a),
    .register_read_enable_b(register_read_enable_b),
    .register_read_address_b(register_read_address_b),
    .register_read_data_b(register_read_data_b),
    .register_write_enable(register_write_enable),
    .register_write_address(register_write_address),
    .register_write_data(register_write_data),
    .debug_address(debug_address),
    .debug_data(debug_data),
    .ready(ready),
    .write_dropped(write_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: contents, ready after 31 reset-free edges, sticky drop flag.
  logic [31:0] m_mem [32];
  bit          m_valid = 0;
  bit          m_ready = 0;
  bit          m_drop  = 0;
  int          m_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
    if (reset || !m_ready || !en || addr == 5'd0) return 32'd0;
    if (register_write_enable && register_write_address == addr) return register_write_data;
    return m_mem[addr];
  endfunction

  function automatic logic [31:0] exp_debug();
    if (!m_ready || debug_address == 5'd0) return 32'd0;
    return m_mem[debug_address];
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_valid = 1;
      m_ready = 0;
      m_drop  = 0;
      m_count = 0;
    end else if (m_valid) begin
      if (m_ready) begin
        if (register_write_enable && register_write_address != 5'd0)
          m_mem[register_write_address] = register_write_data;
      end else begin
        if (register_write_enable && register_write_address != 5'd0) m_drop = 1;
        m_count++;
        if (m_count == 31) begin
          m_ready = 1;
          for (int i = 1; i < 32; i++) m_mem[i] = 32'd0;
        end
      end
    end
  endtask

  // Check outputs against the model before the edge, then advance one clock.
  task automatic tick();
    #2;
    if (m_valid) begin
      chk("model_ready", {31'd0, ready}, {31'd0, m_ready});
      chk("model_drop", {31'd0, write_dropped}, {31'd0, m_drop});
      chk("model_rd_a", register_read_data_a, exp_read(register_read_enable_a, register_read_address_a));
      chk("model_rd_b", register_read_data_b, exp_read(register_read_enable_b, register_read_address_b));
      chk("model_debug", debug_data, exp_debug());
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ea;
    logic [4:0]  aa;
    logic        eb;
    logic [4:0]  ab;
    logic [4:0]  da;
    logic [31:0] xa;
    logic [31:0] xb;
    logic [31:0] xd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5,  1'b0, 5'd5,  5'd5,  32'h0,        32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'd5,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b1, 5'd5,  5'd5,  32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd5,  1'b1, 5'd7,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'h0};
    tbl[4]  = '{1'b0, 5'd7,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h12345678};
    tbl[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[7]  = '{1'b1, 5'd5,  32'h0BADF00D, 1'b1, 5'd5,  1'b1, 5'd5,  5'd5,  32'h0BADF00D, 32'h0BADF00D, 32'hDEADBEEF};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd1,  5'd5,  32'h0,        32'h0,        32'h0BADF00D};
    tbl[9]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 1'b0, 5'd31, 5'd31, 32'hA5A5A5A5, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd7,  5'd31, 32'hA5A5A5A5, 32'h12345678, 32'hA5A5A5A5};

    reset = 1'b1;
    register_read_enable_a = 1'b0;
    register_read_address_a = 5'd0;
    register_read_enable_b = 1'b0;
    register_read_address_b = 5'd0;
    register_write_enable = 1'b0;
    register_write_address = 5'd0;
    register_write_data = 32'd0;
    debug_address = 5'd0;

    tick();
    tick();
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_drop", {31'd0, write_dropped}, 32'd0);

    // Clear with a dropped write at cycle 3 and a reset at cycle 10.
    for (int c = 1; c <= 10; c++) begin
      reset = (c == 10);
      register_write_enable = (c == 3);
      register_write_address = 5'd9;
      register_write_data = 32'h0000AAAA;
      debug_address = 5'(c);
      tick();
      if (c == 3) chk("drop_set", {31'd0, write_dropped}, 32'd1);
      if (c < 10) chk("early_ready", {31'd0, ready}, 32'd0);
    end
    chk("drop_cleared", {31'd0, write_dropped}, 32'd0);
    chk("ready_after_rst", {31'd0, ready}, 32'd0);

    reset = 1'b0;
    register_write_enable = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("clear_length", 32'(n), 32'd31);

    register_read_enable_a = 1'b1;
    register_read_address_a = 5'd9;
    for (int i = 0; i < 32; i++) begin
      debug_address = 5'(i);
      #1;
      chk("sweep_debug", debug_data, 32'd0);
      tick();
    end
    chk("r9_after_clear", register_read_data_a, 32'd0);

    for (int v = 0; v < 11; v++) begin
      register_write_enable = tbl[v].we;
      register_write_address = tbl[v].wa;
      register_write_data = tbl[v].wd;
      register_read_enable_a = tbl[v].ea;
      register_read_address_a = tbl[v].aa;
      register_read_enable_b = tbl[v].eb;
      register_read_address_b = tbl[v].ab;
      debug_address = tbl[v].da;
      #2;
      chk($sformatf("vec%0d_a", v), register_read_data_a, tbl[v].xa);
      chk($sformatf("vec%0d_b", v), register_read_data_b, tbl[v].xb);
      chk($sformatf("vec%0d_dbg", v), debug_data, tbl[v].xd);
      chk($sformatf("vec%0d_drop", v), {31'd0, write_dropped}, 32'd0);
      tick();
    end

    // Randomized traffic, with small addresses favoured to provoke bypass hits.
    for (int r = 0; r < 600; r++) begin
      reset = ($urandom_range(0, 149) == 0);
      register_write_enable = ($urandom_range(0, 1) == 1);
      register_write_address = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      register_write_data = $urandom;
      register_read_enable_a = ($urandom_range(0, 3) != 0);
      register_read_address_a = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      register_read_enable_b = ($urandom_range(0, 3) != 0);
      register_read_address_b = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      debug_address = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
